shift_readout_ctrl: RTL and testbench

SHIFT_READOUT_CTRL -- requirements
Module: shift_readout_ctrl

---
 rtl/readout_pkg.sv | 14 +
 rtl/shift_readout_ctrl.sv | 94 +++++++++
 tb/tb_shift_readout_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/readout_pkg.sv
// Shared types for the shift-register readout controller: FSM state encoding
// and the completed-frame counter width.
package readout_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/shift_readout_ctrl.sv
// Serial readout controller: streams WIDTH source bits into an external shift
// register, strobes its capture, then reports done. Optional underrun flag under
// macro SHIFT_READOUT_UNDERRUN_EN.
module shift_readout_ctrl
    import readout_pkg::*;
#(
    parameter int WIDTH = 512,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   src_valid,
    input  logic                   src_bit,
    output logic                   src_ready,
    output logic                   sr_shift_in,
    output logic                   sr_load,
    output logic                   busy,
    output logic                   done,
    output logic                   underrun,
    output logic [CNT_W-1:0]       bit_count,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    state_t                 r_state;
    logic [CNT_W-1:0]       r_bit_count;
    logic [FRAME_CNT_W-1:0] r_frame_count;
    logic                   w_in_shift;
    logic                   w_last_bit;

    assign w_in_shift = (r_state == SHIFT);
    assign w_last_bit = (r_bit_count == CNT_W'(WIDTH - 1));

`ifdef SHIFT_READOUT_UNDERRUN_EN
    logic r_underrun;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_underrun <= 1'b0;
        end else if (r_state == IDLE && start && !abort) begin
            r_underrun <= 1'b0;
        end else if (w_in_shift && !abort && !src_valid) begin
            r_underrun <= 1'b1;
        end
    end

    assign underrun = (r_state == DONE) & r_underrun;
`else
    assign underrun = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_bit_count   <= '0;
            r_frame_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // abort outranks start, so a simultaneous pair is a no-op
                    if (start && !abort) begin
                        r_state     <= SHIFT;
                        r_bit_count <= '0;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        r_state <= IDLE;
                    end else begin
                        r_bit_count <= r_bit_count + CNT_W'(1);
                        if (w_last_bit) r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_state       <= DONE;
                    r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Missing source data is zero-filled rather than stalling the shift register.
    assign src_ready   = w_in_shift;
    assign sr_shift_in = w_in_shift & src_valid & src_bit;
    assign sr_load     = (r_state == LOAD);
    assign busy        = (r_state != IDLE);
    assign done        = (r_state == DONE);
    assign bit_count   = r_bit_count;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_shift_readout_ctrl.sv
// Bench for shift_readout_ctrl (WIDTH=8) with a shift register modelled alongside;
// honours SHIFT_READOUT_UNDERRUN_EN when defined.
module tb_shift_readout_ctrl;
    localparam int W   = 8;
    localparam int CW  = $clog2(W + 1);
`ifdef SHIFT_READOUT_UNDERRUN_EN
    localparam bit UND_EN = 1'b1;
`else
    localparam bit UND_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0, abort = 1'b0, src_valid = 1'b0, src_bit = 1'b0;
    logic          src_ready, sr_shift_in, sr_load, busy, done, underrun;
    logic [CW-1:0] bit_count;
    logic [15:0]   frame_count;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    shift_readout_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .src_valid(src_valid), .src_bit(src_bit), .src_ready(src_ready),
        .sr_shift_in(sr_shift_in), .sr_load(sr_load), .busy(busy), .done(done),
        .underrun(underrun), .bit_count(bit_count), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    // Shift register next to the controller: shifts every cycle, captures on sr_load.
    logic [W-1:0] sr = '0, q = '0;
    always @(posedge clk) begin
        sr <= {sr[W-2:0], sr_shift_in};
        if (sr_load) q <= sr;
    end

    // Reference model. m_ph counts cycles into the frame: 0 idle, 1..W shifting,
    // W+1 capture, W+2 done.
    int       m_ph = 0;
    int       m_bits = 0;
    int       m_fc = 0;
    bit       m_und = 1'b0;
    bit       m_q[$];

    always @(posedge clk) begin
        if (!reset_n) begin
            m_ph = 0; m_bits = 0; m_fc = 0; m_und = 1'b0; m_q.delete();
        end else if (m_ph == 0) begin
            if (start && !abort) begin
                m_ph = 1; m_bits = 0; m_und = 1'b0; m_q.delete();
            end
        end else if (m_ph <= W) begin
            if (abort) m_ph = 0;
            else begin
                m_q.push_back(src_valid & src_bit);
                if (!src_valid) m_und = 1'b1;
                m_bits = m_bits + 1;
                m_ph = m_ph + 1;
            end
        end else if (m_ph == W + 1) begin
            m_ph = W + 2;
            m_fc = (m_fc + 1) % 65536;
        end else begin
            m_ph = 0;
        end
    end

    function automatic logic [W-1:0] packed_frame();
        logic [W-1:0] v = '0;
        for (int i = 0; i < W && i < m_q.size(); i++) v[W-1-i] = m_q[i];
        return v;
    endfunction

    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            logic [5:0] exp_o, act_o;
            bit rdy;
            rdy   = (m_ph >= 1 && m_ph <= W);
            exp_o = {m_ph != 0, rdy, rdy & src_valid & src_bit, m_ph == W + 1,
                     m_ph == W + 2, UND_EN & (m_ph == W + 2) & m_und};
            act_o = {busy, src_ready, sr_shift_in, sr_load, done, underrun};
            checks++;
            if (act_o !== exp_o || bit_count !== CW'(m_bits) || frame_count !== 16'(m_fc)) begin
                failures++;
                $display("FAIL model t=%0t outs=%b/%0d/%0d required %b/%0d/%0d", $time,
                         act_o, bit_count, frame_count, exp_o, m_bits, m_fc);
            end
            if (m_ph == W + 2) begin
                checks++;
                if (q !== packed_frame()) begin
                    failures++;
                    $display("FAIL model_q t=%0t got %h required %h", $time, q, packed_frame());
                end
            end
        end
    end

    task automatic lchk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got %0h required %0h", name, act, exp);
        end
    endtask

    // Start a frame and stream pat MSB-first; optionally drop valid, abort or reset at a bit.
    task automatic send(input logic [7:0] pat, input int inval, input int ab_at, input int rst_at);
        @(negedge clk); start = 1'b1;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            start = 1'b0;
            src_valid = (i != inval);
            src_bit = pat[W-1-i];
            abort = (i == ab_at);
            reset_n = (i != rst_at);
            if (i == ab_at || i == rst_at) break;
        end
        @(negedge clk);
        src_valid = 1'b0; abort = 1'b0; reset_n = 1'b1;
        #2;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        #2;
        lchk("reset_busy", {31'd0, busy}, 0);
        lchk("reset_bitcnt", {28'd0, bit_count}, 0);
        lchk("reset_fc", {16'd0, frame_count}, 0);
        @(negedge clk); reset_n = 1'b1;

        // Frame 1: stream 1,0,1,1,0,0,1,0
        send(8'hB2, -1, -1, -1);
        lchk("load_cycle9", {31'd0, sr_load}, 1);
        @(negedge clk); #2;
        lchk("done_cycle10", {31'd0, done}, 1);
        lchk("q_b2", {24'd0, q}, 32'hB2);
        lchk("fc_1", {16'd0, frame_count}, 1);
        lchk("und_0", {31'd0, underrun}, 0);

        // Frame 2: same stream, bit 3 missing
        send(8'hB2, 3, -1, -1);
        @(negedge clk); #2;
        lchk("q_a2", {24'd0, q}, 32'hA2);
        lchk("und_bit3", {31'd0, underrun}, {31'd0, UND_EN});

        // Abort at bit 4, then a normal frame
        send(8'h5C, -1, 4, -1);
        lchk("abort_idle", {31'd0, busy}, 0);
        lchk("abort_fc", {16'd0, frame_count}, 2);
        repeat (12) @(negedge clk);
        #2;
        lchk("abort_no_done_fc", {16'd0, frame_count}, 2);
        send(8'h3C, -1, -1, -1);
        @(negedge clk); #2;
        lchk("after_abort_q", {24'd0, q}, 32'h3C);
        lchk("after_abort_fc", {16'd0, frame_count}, 3);

        // Reset at bit 5
        send(8'hFF, -1, -1, 5);
        lchk("rst_busy", {31'd0, busy}, 0);
        lchk("rst_bitcnt", {28'd0, bit_count}, 0);
        lchk("rst_fc", {16'd0, frame_count}, 0);

        // start and abort together in IDLE
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); #2;
        lchk("both_idle", {31'd0, busy}, 0);
        start = 1'b0; abort = 1'b0;

        // Counter wrap with start held: DONE -> one IDLE -> SHIFT
        @(negedge clk);
        force dut.r_frame_count = 16'hFFFF;
        m_fc = 16'hFFFF;
        @(negedge clk);
        release dut.r_frame_count;
        start = 1'b1; src_valid = 1'b1; src_bit = 1'b1;
        repeat (10) @(negedge clk);
        #2;
        lchk("wrap_done", {31'd0, done}, 1);
        lchk("wrap_fc", {16'd0, frame_count}, 0);
        @(negedge clk); #2;
        lchk("b2b_idle", {31'd0, busy}, 0);
        @(negedge clk); #2;
        lchk("b2b_shift", {31'd0, src_ready}, 1);

        // Randomized traffic against the model
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            start     = ($urandom_range(0, 2) == 0);
            abort     = ($urandom_range(0, 24) == 0);
            src_valid = ($urandom_range(0, 3) != 0);
            src_bit   = $urandom_range(0, 1) == 1;
            reset_n   = ($urandom_range(0, 299) != 0);
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0; src_valid = 1'b0; reset_n = 1'b1;
        repeat (15) @(negedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
